// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: start-edge detect, edge/bit counting,
// sampler/checker/deserializer enables and the frame-accept strobe.
module uart_rx_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic [5:0] Prescale,
  input  logic       strt_glitch,
  input  logic       par_err,
  input  logic       stp_err,
  output logic [5:0] edge_cnt,
  output logic [3:0] bit_cnt,
  output logic       dat_samp_en,
  output logic       strt_chk_en,
  output logic       par_chk_en,
  output logic       stp_chk_en,
  output logic       deser_en,
  output logic       data_valid
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;
  logic       perr_q, perr_d;
  logic       deser_q, deser_d;
  logic       valid_q, valid_d;
  logic [5:0] last_edge;
  logic       bit_end;

  assign last_edge = Prescale - 6'd1;
  assign bit_end   = (edge_q == last_edge);

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q + 6'd1;
    bit_d   = bit_q;
    perr_d  = perr_q;
    valid_d = 1'b0;
    if (bit_end) begin
      edge_d = 6'd0;
      bit_d  = bit_q + 4'd1;
    end
    unique case (state_q)
      IDLE: begin
        edge_d = 6'd0;
        bit_d  = 4'd0;
        if (!RX_IN) begin
          state_d = START;
          perr_d  = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          if (strt_glitch) begin
            state_d = IDLE;
            bit_d   = 4'd0;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (bit_end && bit_q == 4'd8)
          state_d = PAR_EN ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          perr_d  = par_err;
        end
      end
      STOP: begin
        if (bit_end) begin
          valid_d = !perr_q && !stp_err;
          bit_d   = 4'd0;
          // A low line at stop end is the next start edge
          if (!RX_IN) begin
            state_d = START;
            perr_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        edge_d  = 6'd0;
        bit_d   = 4'd0;
      end
    endcase
    // Strobe lands on the bit-end cycle of each data bit
    deser_d = (state_d == DATA) && (edge_d == last_edge);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      edge_q  <= 6'd0;
      bit_q   <= 4'd0;
      perr_q  <= 1'b0;
      deser_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      perr_q  <= perr_d;
      deser_q <= deser_d;
      valid_q <= valid_d;
    end
  end

  assign edge_cnt    = edge_q;
  assign bit_cnt     = bit_q;
  assign dat_samp_en = (state_q != IDLE);
  assign strt_chk_en = (state_q == START);
  assign par_chk_en  = (state_q == PARITY);
  assign stp_chk_en  = (state_q == STOP);
  assign deser_en    = deser_q;
  assign data_valid  = valid_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: per-cycle comparison against a frame-timeline
// model built from bit positions, plus directed frame-level checks.
module tb_uart_rx_fsm;

  localparam int NC = 1600;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en;
  logic       deser_en, data_valid;

  uart_rx_fsm dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN),
    .Prescale(Prescale), .strt_glitch(strt_glitch),
    .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .dat_samp_en(dat_samp_en), .strt_chk_en(strt_chk_en),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .deser_en(deser_en), .data_valid(data_valid)
  );

  always #5 CLK = ~CLK;

  int nchk = 0;
  int nerr = 0;

  bit       rx_a [NC];
  bit       gl_a [NC];
  bit       pe_a [NC];
  bit       se_a [NC];
  bit       rl_a [NC];
  logic [5:0] ee [NC];
  logic [3:0] eb [NC];
  bit       eact [NC], esc [NC], epc [NC], espc [NC];
  bit       edes [NC], edv [NC];

  int ndes, ndv, dv_first, dv_last, bmax, last_act;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_scn();
    for (int c = 0; c < NC; c++) begin
      rx_a[c] = 1'b1; gl_a[c] = 1'b0; pe_a[c] = 1'b0;
      se_a[c] = 1'b0; rl_a[c] = (c < 2);
      ee[c] = '0; eb[c] = '0; eact[c] = 0; esc[c] = 0;
      epc[c] = 0; espc[c] = 0; edes[c] = 0; edv[c] = 0;
    end
  endtask

  // Frame with start edge at cycle t; returns the last cycle of its final bit
  task automatic add_frame(input int t, input int p, input bit pe,
                           input logic [7:0] b, input bit gl,
                           input bit perr, input bit serr,
                           output int last);
    int len, k, e;
    bit line;
    len = gl ? p : (10 + int'(pe)) * p;
    rx_a[t] = 1'b0;
    for (int rel = 1; rel <= len; rel++) begin
      k = (rel - 1) / p;
      e = (rel - 1) % p;
      if (gl) line = (rel <= 3) ? 1'b0 : 1'b1;
      else if (k == 0) line = 1'b0;
      else if (k <= 8) line = b[k-1];
      else if (k == 9 && pe) line = ^b;
      else line = 1'b1;
      rx_a[t+rel] = line;
      gl_a[t+rel] = (k == 0) ? gl : 1'($urandom_range(0, 1));
      pe_a[t+rel] = perr && (pe ? (k == 9) : 1'b1);
      se_a[t+rel] = (k == 9 + int'(pe)) ? serr : 1'($urandom_range(0, 1));
      ee[t+rel]   = 6'(e);
      eb[t+rel]   = 4'(k);
      eact[t+rel] = 1;
      esc[t+rel]  = (k == 0);
      epc[t+rel]  = pe && (k == 9);
      espc[t+rel] = (k == 9 + int'(pe));
      edes[t+rel] = (k >= 1 && k <= 8 && e == p - 1);
    end
    if (!gl) edv[t+len+1] = !(pe && perr) && !serr;
    last = t + len;
  endtask

  task automatic zero_from(input int c0, input int c1);
    for (int c = c0; c <= c1; c++) begin
      rx_a[c] = 1'b1; gl_a[c] = 0; pe_a[c] = 0; se_a[c] = 0;
      ee[c] = '0; eb[c] = '0; eact[c] = 0; esc[c] = 0;
      epc[c] = 0; espc[c] = 0; edes[c] = 0; edv[c] = 0;
    end
  endtask

  task automatic run_scn(input string name, input int p, input bit pe,
                         input int ncyc);
    logic [15:0] got, exp;
    ndes = 0; ndv = 0; dv_first = -1; dv_last = -1;
    bmax = 0; last_act = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge CLK);
      #1;
      RST = !rl_a[c];
      RX_IN = rx_a[c];
      strt_glitch = gl_a[c];
      par_err = pe_a[c];
      stp_err = se_a[c];
      Prescale = 6'(p);
      PAR_EN = pe;
      #1;
      got = {edge_cnt, bit_cnt, dat_samp_en, strt_chk_en,
             par_chk_en, stp_chk_en, deser_en, data_valid};
      exp = {ee[c], eb[c], eact[c], esc[c], epc[c], espc[c],
             edes[c], edv[c]};
      check($sformatf("%s_c%0d", name, c), 32'(got), 32'(exp));
      if (deser_en) ndes++;
      if (data_valid) begin
        ndv++;
        if (dv_first < 0) dv_first = c;
        dv_last = c;
      end
      if (int'(bit_cnt) > bmax) bmax = int'(bit_cnt);
      if (dat_samp_en) last_act = c;
    end
  endtask

  function automatic int pick_p();
    case ($urandom_range(0, 2))
      0: return 8;
      1: return 16;
      default: return 32;
    endcase
  endfunction

  initial begin
    int e1, e2, rc, t, p, nf, mdv, gap;
    bit pe, gl, prev_gl;
    repeat (2) @(posedge CLK);

    clear_scn();
    add_frame(5, 8, 0, 8'hA5, 0, 0, 0, e1);
    run_scn("a5", 8, 0, e1 + 10);
    check("a5_deser", ndes, 8);
    check("a5_dv_n", ndv, 1);
    check("a5_dv_at", dv_first, 5 + 81);

    clear_scn();
    add_frame(5, 16, 0, 8'h00, 1, 0, 0, e1);
    run_scn("glitch", 16, 0, e1 + 10);
    check("glitch_deser", ndes, 0);
    check("glitch_dv", ndv, 0);
    check("glitch_idle", last_act + 1, 5 + 17);

    clear_scn();
    add_frame(5, 8, 1, 8'h3C, 0, 1, 0, e1);
    run_scn("perr", 8, 1, e1 + 10);
    check("perr_dv", ndv, 0);
    check("perr_bmax", bmax, 10);
    check("perr_deser", ndes, 8);

    clear_scn();
    add_frame(5, 8, 0, 8'h5A, 0, 0, 1, e1);
    run_scn("serr", 8, 0, e1 + 10);
    check("serr_dv", ndv, 0);
    check("serr_idle", last_act, e1);

    clear_scn();
    add_frame(5, 32, 0, 8'h00, 0, 0, 0, e1);
    add_frame(e1, 32, 0, 8'hFF, 0, 0, 0, e2);
    run_scn("b2b", 32, 0, e2 + 10);
    check("b2b_dv_n", ndv, 2);
    check("b2b_gap", dv_last - dv_first, 320);
    check("b2b_deser", ndes, 16);

    clear_scn();
    add_frame(5, 8, 0, 8'hC3, 0, 0, 0, e1);
    rc = 5 + 1 + 5 * 8 + 3;
    zero_from(rc, e1 + 1);
    for (int c = rc; c < rc + 3; c++) rl_a[c] = 1;
    run_scn("rst", 8, 0, e1 + 10);
    check("rst_deser", ndes, 4);
    check("rst_dv", ndv, 0);
    check("rst_idle", last_act, rc - 1);

    for (int it = 0; it < 8; it++) begin
      clear_scn();
      p = pick_p();
      pe = 1'($urandom_range(0, 1));
      nf = $urandom_range(1, 3);
      t = 4 + $urandom_range(0, 5);
      prev_gl = 0;
      for (int f = 0; f < nf; f++) begin
        gl = ($urandom_range(0, 4) == 0);
        add_frame(t, p, pe, 8'($urandom), gl,
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0), e1);
        prev_gl = gl;
        gap = $urandom_range(0, 4);
        if (prev_gl) t = e1 + 1 + gap;
        else if (gap == 0) t = e1;
        else t = e1 + gap;
      end
      mdv = 0;
      for (int c = 0; c < NC; c++) if (edv[c]) mdv++;
      run_scn($sformatf("rnd%0d", it), p, pe, e1 + 10);
      check($sformatf("rnd%0d_dv", it), ndv, mdv);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
